// File: rtl/ysyx_25030093_regfile_sb_if.sv
// Decode/writeback bus for the GPR file with its busy scoreboard.
// Read ports are packed as [NREAD-1:0][W-1:0], so port i sits at bits [i*W +: W].
interface ysyx_25030093_regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2
);
  localparam int NREGS = 2**ADDR_WIDTH;

  logic                                wen;
  logic [ADDR_WIDTH-1:0]               waddr;
  logic [DATA_WIDTH-1:0]               wdata;
  logic [NREAD-1:0][ADDR_WIDTH-1:0]    raddr;
  logic [NREAD-1:0]                    rd_use;
  logic [NREAD-1:0][DATA_WIDTH-1:0]    rdata;
  logic                                issue_valid;
  logic [ADDR_WIDTH-1:0]               issue_rd;
  logic [NREGS-1:0]                    busy_vec;
  logic                                hazard;

  modport master (
    output wen, waddr, wdata, raddr, rd_use, issue_valid, issue_rd,
    input  rdata, busy_vec, hazard
  );

  modport slave (
    input  wen, waddr, wdata, raddr, rd_use, issue_valid, issue_rd,
    output rdata, busy_vec, hazard
  );
endinterface

// File: rtl/ysyx_25030093_regfile_sb.sv
// GPR file with NREAD read ports, one write port and a busy scoreboard driving the decode stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_25030093_regfile_sb_rport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  rd_use,
  input  logic [DATA_WIDTH-1:0] stored,
  input  logic                  busy_bit,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  raw
);
  logic is_zero;
  logic fwd;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd = wen && (waddr == raddr) && !is_zero;
`else
  // Without bypass the writeback inputs are only consumed by the array itself.
  logic unused_wb;
  assign unused_wb = ^{wen, waddr, wdata};
  assign fwd       = 1'b0;
`endif

  always_comb begin
    rdata = stored;
    if (fwd) rdata = wdata;
    if (is_zero || !rst_n) rdata = '0;
  end

  assign raw = rst_n && rd_use && busy_bit && !fwd && !is_zero;
endmodule

module ysyx_25030093_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int ZERO_REG   = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_25030093_regfile_sb_if.slave bus
);
  localparam int NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] rf;
  logic [NREGS-1:0]                 busy;
  logic [NREGS-1:0]                 busy_nxt;
  logic [NREAD-1:0][DATA_WIDTH-1:0] stored;
  logic [NREAD-1:0]                 raw;
  logic                             waw;
  logic                             hazard_int;
  logic                             wr_ok;

  assign wr_ok = bus.wen && !((ZERO_REG != 0) && (bus.waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf <= '0;
    else if (wr_ok) rf[bus.waddr] <= bus.wdata;
  end

  genvar i;
  generate
    for (i = 0; i < NREAD; i++) begin : g_rport
      assign stored[i] = rf[bus.raddr[i]];
      ysyx_25030093_regfile_sb_rport #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ZERO_REG  (ZERO_REG)
      ) u_rport (
        .rst_n   (rst_n),
        .raddr   (bus.raddr[i]),
        .rd_use  (bus.rd_use[i]),
        .stored  (stored[i]),
        .busy_bit(busy[bus.raddr[i]]),
        .wen     (bus.wen),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .rdata   (bus.rdata[i]),
        .raw     (raw[i])
      );
    end
  endgenerate

  // WAW: an issue must not overtake an older in-flight writer of the same register.
  assign waw = rst_n && bus.issue_valid && busy[bus.issue_rd]
            && !((ZERO_REG != 0) && (bus.issue_rd == '0));
  assign hazard_int = (|raw) || waw;

  // Clear from writeback first so a same-cycle issue (the younger writer) wins.
  always_comb begin
    busy_nxt = busy;
    if (bus.wen) busy_nxt[bus.waddr] = 1'b0;
    if (bus.issue_valid && !hazard_int) busy_nxt[bus.issue_rd] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign bus.busy_vec = busy;
  assign bus.hazard   = hazard_int;
endmodule

// File: tb/tb_ysyx_25030093_regfile_sb.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor compares them.
// Expectations follow the build: REGFILE_BYPASS_EN defined or not.
module tb_ysyx_25030093_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_25030093_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(3)) b ();
  ysyx_25030093_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(1)) zb ();

  ysyx_25030093_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));
  ysyx_25030093_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(1), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(zb.slave));

  // Second instance (x0 ordinary) shadows the writeback and read port 0 of the first.
  assign zb.wen         = b.wen;
  assign zb.waddr       = b.waddr;
  assign zb.wdata       = b.wdata;
  assign zb.raddr       = b.raddr[0];
  assign zb.rd_use      = 1'b0;
  assign zb.issue_valid = 1'b0;
  assign zb.issue_rd    = '0;

  typedef struct {
    int          kind;   // 0 rdata[idx], 1 busy bit idx, 2 hazard, 3 busy_vec, 4 zero-reg-off rdata
    int          idx;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic expect_out(input int kind, input int idx, input logic [31:0] val, input string name);
    chk_t c;
    c.kind = kind; c.idx = idx; c.val = val; c.name = name;
    q.push_back(c);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] got;
      c = q.pop_front();
      case (c.kind)
        0:       got = b.rdata[c.idx];
        1:       got = {31'd0, b.busy_vec[c.idx]};
        2:       got = {31'd0, b.hazard};
        3:       got = b.busy_vec;
        default: got = zb.rdata[0];
      endcase
      checks++;
      if (got === c.val) passed++;
      else $display("FAIL %s: got %h expected %h", c.name, got, c.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic iv, input logic [4:0] ird, input logic [2:0] use_,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    b.wen = wen; b.waddr = waddr; b.wdata = wdata;
    b.issue_valid = iv; b.issue_rd = ird; b.rd_use = use_;
    b.raddr[0] = r0; b.raddr[1] = r1; b.raddr[2] = r2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_out(3, 0, 32'h0, "reset_busy_vec");
    expect_out(2, 0, 32'h0, "reset_hazard");
    expect_out(0, 0, 32'h0, "reset_rdata0");
    step();
    rst_n = 1'b1;

    // Reset mid-run
    step();
    drive(1, 5, 32'h1234, 1, 7, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h0, "t1_issue_hazard");
    step();
    drive(0, 0, 0, 0, 0, 3'b010, 5, 7, 0);
    expect_out(0, 0, 32'h1234, "t1_x5_read");
    expect_out(1, 7, 32'h1, "t1_busy7_set");
    expect_out(2, 0, 32'h1, "t1_raw_x7");
    step();
    rst_n = 1'b0;
    expect_out(0, 0, 32'h0, "t1_rst_rdata");
    expect_out(3, 0, 32'h0, "t1_rst_busy_vec");
    expect_out(2, 0, 32'h0, "t1_rst_hazard");
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 3'b000, 5, 7, 0);
    expect_out(0, 0, 32'h0, "t1_x5_cleared");

    // x0 handling
    step();
    drive(1, 0, 32'hDEADBEEF, 1, 0, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h0, "t2_x0_issue_hazard");
    step();
    drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_out(0, 0, 32'h0, "t2_x0_reads_zero");
    expect_out(1, 0, 32'h0, "t2_busy0_clear");
    expect_out(3, 0, 32'h0, "t2_busy_vec");
    expect_out(4, 0, 32'hDEADBEEF, "t2_x0_ordinary");

    // RAW on x3
    step();
    drive(0, 0, 0, 1, 3, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h0, "t3_issue_hazard");
    step();
    drive(0, 0, 0, 0, 0, 3'b001, 3, 0, 0);
    expect_out(2, 0, 32'h1, "t3_raw_stall");
    expect_out(1, 3, 32'h1, "t3_busy3");
    step();
    drive(1, 3, 32'h55, 0, 0, 3'b001, 3, 0, 0);
`ifdef REGFILE_BYPASS_EN
    expect_out(0, 0, 32'h55, "t3_bypass_rdata");
    expect_out(2, 0, 32'h0, "t3_bypass_hazard");
`else
    expect_out(0, 0, 32'h0, "t3_old_rdata");
    expect_out(2, 0, 32'h1, "t3_wb_cycle_hazard");
`endif
    step();
    drive(0, 0, 0, 0, 0, 3'b001, 3, 0, 0);
    expect_out(2, 0, 32'h0, "t3_hazard_released");
    expect_out(0, 0, 32'h55, "t3_rdata_after");
    expect_out(1, 3, 32'h0, "t3_busy3_clear");

    // WAW on x4
    step();
    drive(0, 0, 0, 1, 4, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h0, "t4_first_issue");
    step();
    drive(1, 4, 32'h44, 1, 4, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h1, "t4_waw_stall");
    step();
    drive(1, 4, 32'h45, 1, 4, 3'b000, 0, 0, 0);
    expect_out(1, 4, 32'h0, "t4_busy4_cleared");
    expect_out(2, 0, 32'h0, "t4_issue_ok");
    step();
    drive(0, 0, 0, 0, 0, 3'b000, 4, 0, 0);
    expect_out(1, 4, 32'h1, "t4_set_wins");
    expect_out(0, 0, 32'h45, "t4_x4_data");

    // Multi-port hazard selection (x4 busy)
    step();
    drive(0, 0, 0, 0, 0, 3'b100, 0, 4, 5);
    expect_out(2, 0, 32'h0, "t5_unused_port_busy");
    step();
    drive(0, 0, 0, 0, 0, 3'b010, 0, 4, 5);
    expect_out(2, 0, 32'h1, "t5_port1_raw");
    step();
    drive(1, 4, 32'h46, 0, 0, 3'b000, 0, 0, 0);

    // Max address
    step();
    drive(0, 0, 0, 1, 31, 3'b000, 0, 0, 0);
    expect_out(2, 0, 32'h0, "t6_issue31");
    step();
    drive(1, 31, 32'hFFFFFFFF, 0, 0, 3'b000, 31, 31, 31);
    expect_out(1, 31, 32'h1, "t6_busy31_set");
    expect_out(1, 4, 32'h0, "t6_busy4_cleared");
    step();
    drive(0, 0, 0, 0, 0, 3'b000, 31, 31, 31);
    expect_out(0, 0, 32'hFFFFFFFF, "t6_rdata0");
    expect_out(0, 1, 32'hFFFFFFFF, "t6_rdata1");
    expect_out(0, 2, 32'hFFFFFFFF, "t6_rdata2");
    expect_out(1, 31, 32'h0, "t6_busy31_clear");
    expect_out(3, 0, 32'h0, "t6_busy_vec_idle");

    step();
    step();
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
